prog_loader: RTL and testbench

//  Writes a program into instruction memory from a byte stream (host, UART RX or bench),

---
 rtl/prog_loader_pkg.sv | 22 ++
 rtl/prog_loader_if.sv | 24 ++
 rtl/prog_loader_word_packer.sv | 40 ++++
 rtl/prog_loader.sv | 152 +++++++++++++++
 tb/tb_prog_loader.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared constants, FSM encoding and checksum helper for the program loader.
package prog_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  function automatic logic [BYTE_W-1:0] csum_step(input logic [BYTE_W-1:0] acc,
                                                  input logic [BYTE_W-1:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [BYTE_W-1:0] byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_loader_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream; word_valid pulses with the 4th byte.
module prog_loader_word_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [1:0]  idx_r;
  logic [23:0] lo_r;

  // Byte index and the three lower bytes of the word being assembled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r <= 2'd0;
      lo_r  <= 24'd0;
    end else if (clear) begin
      idx_r <= 2'd0;
      lo_r  <= 24'd0;
    end else if (byte_en) begin
      idx_r <= idx_r + 2'd1;
      case (idx_r)
        2'd0:    lo_r[7:0]   <= byte_in;
        2'd1:    lo_r[15:8]  <= byte_in;
        2'd2:    lo_r[23:16] <= byte_in;
        default: lo_r        <= lo_r;
      endcase
    end
  end

  // The top byte is taken straight from the stream so the word is complete on the 4th byte
  assign word       = {byte_in, lo_r};
  assign word_valid = byte_en && (idx_r == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Loads a LEN/payload/CSUM framed program into imem, then releases the CPU from reset.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = WORD_W,
  parameter int TIMEOUT = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  prog_loader_if.slave    bus,
  output logic            cpu_rst,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int WL_W  = ADDR_W + 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e              state_r, state_next_s;
  logic                accept_s, start_ok_s, tmo_hit_s, len_ok_s;
  logic                pk_valid_s;
  logic [WORD_W-1:0]   pk_word_s;
  logic [ADDR_W-1:0]   addr_r, imem_addr_r;
  logic [WL_W-1:0]     words_left_r;
  logic [BYTE_W-1:0]   csum_r;
  logic [TMO_W-1:0]    tmo_r;
  logic [DATA_W-1:0]   imem_wdata_r;
  logic                imem_we_r, byte_ready_r, busy_r, done_r, err_r, cpu_rst_r;

  assign accept_s  = bus.byte_valid && byte_ready_r;
  assign len_ok_s  = (bus.byte_in != 8'd0) && (32'(bus.byte_in) <= 32'(DEPTH));
  assign tmo_hit_s = (TIMEOUT != 0) && !accept_s && (tmo_r == TMO_W'(TIMEOUT - 1));

  prog_loader_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok_s),
    .byte_en    (accept_s && (state_r == ST_DATA)),
    .byte_in    (bus.byte_in),
    .word       (pk_word_s),
    .word_valid (pk_valid_s)
  );

  // Next-state decode; a stalled stream times out from any busy state
  always_comb begin
    state_next_s = state_r;
    start_ok_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_next_s = ST_LEN;
          start_ok_s   = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_LEN: begin
        if (accept_s) begin
          state_next_s = len_ok_s ? ST_DATA : ST_ERR;
        end else if (tmo_hit_s) begin
          state_next_s = ST_ERR;
        end else begin
          state_next_s = ST_LEN;
        end
      end
      ST_DATA: begin
        if (pk_valid_s && (words_left_r == WL_W'(1))) begin
          state_next_s = ST_CSUM;
        end else if (tmo_hit_s) begin
          state_next_s = ST_ERR;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (accept_s) begin
          state_next_s = (bus.byte_in == csum_r) ? ST_DONE : ST_ERR;
        end else if (tmo_hit_s) begin
          state_next_s = ST_ERR;
        end else begin
          state_next_s = ST_CSUM;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, counters, checksum and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      addr_r       <= '0;
      imem_addr_r  <= '0;
      imem_wdata_r <= '0;
      imem_we_r    <= 1'b0;
      words_left_r <= '0;
      csum_r       <= 8'd0;
      tmo_r        <= '0;
      byte_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      cpu_rst_r    <= 1'b1;
    end else begin
      state_r   <= state_next_s;
      imem_we_r <= pk_valid_s;
      if (start_ok_s) begin
        addr_r      <= '0;
        imem_addr_r <= '0;
        csum_r      <= 8'd0;
        tmo_r       <= '0;
      end
      if ((state_r == ST_LEN) && accept_s) begin
        words_left_r <= WL_W'(bus.byte_in);
      end
      if ((state_r == ST_DATA) && accept_s) begin
        csum_r <= csum_step(csum_r, bus.byte_in);
      end
      // Write goes out the cycle after the 4th byte, at the address before increment
      if (pk_valid_s) begin
        imem_wdata_r <= pk_word_s;
        imem_addr_r  <= addr_r;
        addr_r       <= addr_r + ADDR_W'(1);
        words_left_r <= words_left_r - WL_W'(1);
      end
      if (busy_r) begin
        tmo_r <= accept_s ? '0 : tmo_r + TMO_W'(1);
      end
      byte_ready_r <= (state_next_s == ST_LEN) || (state_next_s == ST_DATA) ||
                      (state_next_s == ST_CSUM);
      busy_r       <= (state_next_s == ST_LEN) || (state_next_s == ST_DATA) ||
                      (state_next_s == ST_CSUM);
      done_r       <= (state_next_s == ST_DONE);
      err_r        <= (state_next_s == ST_ERR);
      cpu_rst_r    <= (state_next_s != ST_DONE);
    end
  end

  assign bus.byte_ready = byte_ready_r;
  assign bus.imem_we    = imem_we_r;
  assign bus.imem_addr  = imem_addr_r;
  assign bus.imem_wdata = imem_wdata_r;
  assign cpu_rst        = cpu_rst_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign err            = err_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framed loads, checksum/length errors, timeout and reset.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic cpu_rst, busy, done, err;

  prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int                checks = 0;
  int                errors = 0;
  int                wr_cnt = 0;
  logic [31:0]       mem [32];
  logic [ADDR_W-1:0] last_addr = '0;
  logic [7:0]        frame_q [$];

  // imem model: capture each write strobe mid-cycle
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      mem[bus.imem_addr] = bus.imem_wdata;
      last_addr          = bus.imem_addr;
      wr_cnt             = wr_cnt + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   n   = 0;
    logic rdy = 1'b0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    do begin
      rdy = bus.byte_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    bus.byte_valid = 1'b0;
    if (!rdy) check_val("rdy_wait", 32'(rdy), 32'd1);
  endtask

  task automatic send_frame(input int gap);
    foreach (frame_q[i]) begin
      send_byte(frame_q[i]);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic check_flags(input string tag, input logic d, input logic e, input logic c,
                             input logic b);
    check_val({tag, "_done"},    32'(done),    32'(d));
    check_val({tag, "_err"},     32'(err),     32'(e));
    check_val({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(c));
    check_val({tag, "_busy"},    32'(busy),    32'(b));
  endtask

  task automatic check_reset_outs(input string tag);
    check_flags(tag, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    check_val({tag, "_we"},    32'(bus.imem_we),    32'd0);
    check_val({tag, "_addr"},  32'(bus.imem_addr),  32'd0);
    check_val({tag, "_wdata"}, bus.imem_wdata,      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;

    // 1: reset state
    repeat (2) @(posedge clk);
    settle();
    check_reset_outs("rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 2: good two-word frame
    wr_cnt = 0;
    pulse_start();
    check_val("t2_busy", 32'(busy), 32'd1);
    check_val("t2_ready", 32'(bus.byte_ready), 32'd1);
    frame_q = '{8'h02, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h70};
    send_frame(0);
    settle();
    check_flags("t2", 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("t2_ready_off", 32'(bus.byte_ready), 32'd0);
    repeat (3) @(posedge clk);
    settle();
    check_val("t2_wr_cnt", 32'(wr_cnt), 32'd2);
    check_val("t2_mem0", mem[0], 32'h00500013);
    check_val("t2_mem1", mem[1], 32'h00A00093);

    // 3: bad checksum, words still written
    wr_cnt = 0;
    pulse_start();
    check_val("t3_done_clr", 32'(done), 32'd0);
    frame_q[9] = 8'h71;
    send_frame(0);
    settle();
    check_flags("t3", 1'b0, 1'b1, 1'b1, 1'b0);
    check_val("t3_wr_cnt", 32'(wr_cnt), 32'd2);

    // 4: LEN = 0 and LEN = 33
    wr_cnt = 0;
    pulse_start();
    check_val("t4_err_clr", 32'(err), 32'd0);
    send_byte(8'h00);
    settle();
    check_flags("t4a", 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_start();
    send_byte(8'h21);
    settle();
    check_val("t4b_err", 32'(err), 32'd1);
    check_val("t4_wr_cnt", 32'(wr_cnt), 32'd0);

    // Full-depth frame: bytes 0..127, XOR of 0..127 is 0
    wr_cnt = 0;
    @(posedge clk);
    #1;
    frame_q = {};
    frame_q.push_back(8'h20);
    for (int i = 0; i < 128; i++) frame_q.push_back(8'(i));
    frame_q.push_back(8'h00);
    pulse_start();
    send_frame(0);
    settle();
    check_flags("full", 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("full_wr_cnt", 32'(wr_cnt), 32'd32);
    check_val("full_mem0", mem[0], 32'h03020100);
    check_val("full_mem31", mem[31], 32'h7F7E7D7C);
    check_val("full_last_addr", 32'(last_addr), 32'd31);

    // 5a: gaps of 3 cycles between bytes
    wr_cnt = 0;
    @(posedge clk);
    #1;
    frame_q = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    pulse_start();
    send_frame(3);
    settle();
    check_flags("gap", 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("gap_mem0", mem[0], 32'h12345678);

    // 5b: stall after two payload bytes
    wr_cnt = 0;
    @(posedge clk);
    #1;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (TIMEOUT - 1) @(posedge clk);
    settle();
    check_val("tmo_busy_before", 32'(busy), 32'd1);
    @(posedge clk);
    settle();
    check_flags("tmo", 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    settle();
    check_val("tmo_wr_cnt", 32'(wr_cnt), 32'd0);

    // 6a: start during DATA is ignored
    wr_cnt = 0;
    @(posedge clk);
    #1;
    pulse_start();
    frame_q = '{8'h02, 8'h13, 8'h00};
    send_frame(0);
    pulse_start();
    frame_q = '{8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00, 8'h70};
    send_frame(0);
    settle();
    check_flags("ign", 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("ign_wr_cnt", 32'(wr_cnt), 32'd2);
    check_val("ign_mem1", mem[1], 32'h00A00093);

    // 6b: reset mid-DATA, then a fresh frame writes at address 0
    @(posedge clk);
    #1;
    pulse_start();
    frame_q = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame(0);
    rst = 1'b0;
    #1;
    check_reset_outs("mid_rst");
    @(posedge clk);
    #1;
    rst    = 1'b1;
    wr_cnt = 0;
    @(posedge clk);
    #1;
    pulse_start();
    frame_q = '{8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    send_frame(0);
    settle();
    check_flags("fresh", 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("fresh_wr_cnt", 32'(wr_cnt), 32'd1);
    check_val("fresh_addr", 32'(last_addr), 32'd0);
    check_val("fresh_mem0", mem[0], 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
